// File: rtl/iob_plic_claim_agent.sv
// iob_plic_claim_agent: services one PLIC target. It claims the pending ID over IOb,
// hands the ID to a local consumer, waits for the consumer's done pulse, writes the ID
// back to complete it, and then idles for a short settling interval before it samples
// irq again.
module iob_plic_claim_agent #(
  parameter int unsigned          ADDR_W       = 16,
  parameter int unsigned          DATA_W       = 32,
  parameter int unsigned          ID_W         = 7,
  parameter logic [ADDR_W-1:0]    CLAIM_ADDR   = '0,
  parameter int unsigned          REARM_CYCLES = 2,
  parameter int unsigned          CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  irq,
  output logic                  valid,
  output logic [ADDR_W-1:0]     address,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  input  logic [DATA_W-1:0]     rdata,
  input  logic                  ready,
  output logic                  id_valid,
  output logic [ID_W-1:0]       id,
  input  logic                  id_ready,
  input  logic                  done,
  output logic                  busy,
  output logic [CNT_W-1:0]      spurious_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLAIM,
    S_DISPATCH,
    S_SERVICE,
    S_COMPLETE,
    S_REARM
  } state_t;

  localparam logic [7:0] REARM_LD = 8'(REARM_CYCLES);

  state_t               state_q,  state_d;
  logic                 valid_q,  valid_d;
  logic [DATA_W/8-1:0]  wstrb_q,  wstrb_d;
  logic [DATA_W-1:0]    wdata_q,  wdata_d;
  logic                 idv_q,    idv_d;
  logic [ID_W-1:0]      id_q,     id_d;
  logic                 busy_q;
  logic [CNT_W-1:0]     spur_q,   spur_d;
  logic [7:0]           rearm_q,  rearm_d;

  logic [ID_W-1:0]      rd_id;
  logic                 unused_rdata_hi;

  // Only the low ID_W bits of the claim register carry the ID.
  assign rd_id           = rdata[ID_W-1:0];
  assign unused_rdata_hi = ^rdata[DATA_W-1:ID_W];

  // Next-state logic for the claim / dispatch / complete sequence.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    wstrb_d = wstrb_q;
    wdata_d = wdata_q;
    idv_d   = idv_q;
    id_d    = id_q;
    spur_d  = spur_q;
    rearm_d = rearm_q;

    case (state_q)
      S_IDLE: begin
        if (irq && (rearm_q == '0)) begin
          state_d = S_CLAIM;
          valid_d = 1'b1;
          wstrb_d = '0;
        end
      end

      S_CLAIM: begin
        if (ready) begin
          valid_d = 1'b0;
          id_d    = rd_id;
          if (rd_id == '0) begin
            if (spur_q != '1) spur_d = spur_q + CNT_W'(1);
            rearm_d = REARM_LD;
            state_d = S_REARM;
          end else begin
            idv_d   = 1'b1;
            state_d = S_DISPATCH;
          end
        end
      end

      // A done that coincides with the ID handshake skips SERVICE entirely.
      S_DISPATCH: begin
        if (id_ready) begin
          idv_d = 1'b0;
          if (done) begin
            state_d = S_COMPLETE;
            valid_d = 1'b1;
            wstrb_d = '1;
            wdata_d = DATA_W'(id_q);
          end else begin
            state_d = S_SERVICE;
          end
        end
      end

      S_SERVICE: begin
        if (done) begin
          state_d = S_COMPLETE;
          valid_d = 1'b1;
          wstrb_d = '1;
          wdata_d = DATA_W'(id_q);
        end
      end

      S_COMPLETE: begin
        if (ready) begin
          valid_d = 1'b0;
          wstrb_d = '0;
          rearm_d = REARM_LD;
          state_d = S_REARM;
        end
      end

      S_REARM: begin
        rearm_d = rearm_q - 8'd1;
        if (rearm_q <= 8'd1) begin
          rearm_d = '0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      wstrb_q <= '0;
      wdata_q <= '0;
      idv_q   <= 1'b0;
      id_q    <= '0;
      busy_q  <= 1'b0;
      spur_q  <= '0;
      rearm_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      wstrb_q <= wstrb_d;
      wdata_q <= wdata_d;
      idv_q   <= idv_d;
      id_q    <= id_d;
      busy_q  <= (state_d != S_IDLE);
      spur_q  <= spur_d;
      rearm_q <= rearm_d;
    end
  end

  assign valid        = valid_q;
  assign address      = CLAIM_ADDR;
  assign wdata        = wdata_q;
  assign wstrb        = wstrb_q;
  assign id_valid     = idv_q;
  assign id           = id_q;
  assign busy         = busy_q;
  assign spurious_cnt = spur_q;

endmodule

// File: tb/tb_iob_plic_claim_agent.sv
// Scoreboard bench for iob_plic_claim_agent: the stimulus pushes the expected bus and
// ID events, and a negedge monitor pops and compares each handshake.
module tb_iob_plic_claim_agent;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 7;
  localparam int unsigned REARM  = 2;
  localparam int unsigned CNT_W  = 16;
  localparam logic [15:0] CADDR  = 16'h0040;

  logic              clk, rst, irq, ready, id_ready, done;
  logic [DATA_W-1:0] rdata;
  logic              valid, id_valid, busy;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        wstrb;
  logic [ID_W-1:0]   id;
  logic [CNT_W-1:0]  spurious_cnt;
  logic [1:0]        spur_small;

  logic              unused_s_valid, unused_s_idv, unused_s_busy;
  logic [ADDR_W-1:0] unused_s_addr;
  logic [DATA_W-1:0] unused_s_wdata;
  logic [3:0]        unused_s_wstrb;
  logic [ID_W-1:0]   unused_s_id;

  iob_plic_claim_agent #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .CLAIM_ADDR(CADDR),
    .REARM_CYCLES(REARM), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .irq(irq), .valid(valid), .address(address),
    .wdata(wdata), .wstrb(wstrb), .rdata(rdata), .ready(ready),
    .id_valid(id_valid), .id(id), .id_ready(id_ready), .done(done),
    .busy(busy), .spurious_cnt(spurious_cnt)
  );

  // Identical agent with a 2-bit counter, driven by the same inputs.
  iob_plic_claim_agent #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .CLAIM_ADDR(CADDR),
    .REARM_CYCLES(REARM), .CNT_W(2)
  ) dut_s (
    .clk(clk), .rst(rst), .irq(irq), .valid(unused_s_valid), .address(unused_s_addr),
    .wdata(unused_s_wdata), .wstrb(unused_s_wstrb), .rdata(rdata), .ready(ready),
    .id_valid(unused_s_idv), .id(unused_s_id), .id_ready(id_ready), .done(done),
    .busy(unused_s_busy), .spurious_cnt(spur_small)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 read, 1 id handshake, 2 write
    logic [31:0] val;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  fails  = 0;
  int  spur_exp = 0;
  int  spur_small_exp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  endtask

  // Monitor: every handshake must match the front of the expectation queue.
  logic              prev_acc, prev_req_hold, prev_id_hold;
  logic [ADDR_W-1:0] sv_addr;
  logic [DATA_W-1:0] sv_wdata;
  logic [3:0]        sv_wstrb;
  logic [ID_W-1:0]   sv_id;
  int                m_kind;
  ev_t               m_e;

  always @(negedge clk) begin
    if (rst) begin
      prev_acc      = 1'b0;
      prev_req_hold = 1'b0;
      prev_id_hold  = 1'b0;
    end else begin
      if (prev_acc) chk("valid_drop", valid, 0);
      if (prev_req_hold) begin
        chk("addr_stable",  address, sv_addr);
        chk("wstrb_stable", wstrb,   sv_wstrb);
        chk("wdata_stable", wdata,   sv_wdata);
      end
      if (prev_id_hold) chk("id_stable", id, sv_id);

      if (valid) begin
        m_kind = (wstrb == 4'h0) ? 0 : 2;
        chk("req_expected", (exp_q.size() > 0) && (exp_q[0].kind == m_kind), 1);
        if (ready && (exp_q.size() > 0) && (exp_q[0].kind == m_kind)) begin
          m_e = exp_q.pop_front();
          chk("req_addr", address, CADDR);
          if (m_kind == 2) begin
            chk("write_wstrb", wstrb, 4'hF);
            chk("write_wdata", wdata, m_e.val);
          end
        end
      end

      if (id_valid) begin
        chk("id_expected", (exp_q.size() > 0) && (exp_q[0].kind == 1), 1);
        if (id_ready && (exp_q.size() > 0) && (exp_q[0].kind == 1)) begin
          m_e = exp_q.pop_front();
          chk("id_value", id, m_e.val);
        end
      end

      prev_acc      = valid & ready;
      prev_req_hold = valid & ~ready;
      prev_id_hold  = id_valid & ~id_ready;
      sv_addr  = address;
      sv_wstrb = wstrb;
      sv_wdata = wdata;
      sv_id    = id;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit cond(input int w);
    case (w)
      0:       return valid;
      1:       return id_valid;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_for(input string name, input int w, input int limit, output int n);
    n = 0;
    while (!cond(w)) begin
      if (n >= limit) begin
        checks++;
        fails++;
        $display("FAIL %s: timeout after %0d cycles waiting for event", name, n);
        finish_run();
      end
      tick();
      n++;
    end
  endtask

  // Reference model: a claim reads the register; a nonzero low ID field produces
  // an ID handshake and a complete write of that ID, zero-extended.
  task automatic push_txn(input logic [31:0] rd);
    exp_q.push_back('{kind: 0, val: rd});
    if ((rd & 32'h7F) != 0) begin
      exp_q.push_back('{kind: 1, val: rd & 32'h7F});
      exp_q.push_back('{kind: 2, val: rd & 32'h7F});
    end
  endtask

  task automatic run_txn(input logic [31:0] rd, input int st_rd, input int st_wr,
                         input int bp_id, input bit done_w_acc, input int done_dly,
                         input bit hold_irq, input bit chk_lat);
    int n;
    if (!valid) begin
      irq = 1'b1;
      wait_for("claim_valid", 0, 20, n);
      if (chk_lat) chk("irq_to_valid", n, 1);
    end
    if (!hold_irq) irq = 1'b0;

    ready = 1'b0;
    repeat (st_rd) begin
      rdata = $urandom;
      tick();
    end
    ready = 1'b1;
    rdata = rd;
    tick();
    ready = 1'b0;
    rdata = $urandom;

    if ((rd & 32'h7F) == 0) begin
      spur_exp       = (spur_exp == 65535) ? 65535 : spur_exp + 1;
      spur_small_exp = (spur_small_exp == 3) ? 3 : spur_small_exp + 1;
      wait_for("spur_idle", 2, 20, n);
      chk("spur_rearm_len", n, REARM);
      chk("spurious_cnt", spurious_cnt, spur_exp);
      chk("spurious_cnt_w2", spur_small, spur_small_exp);
      return;
    end

    wait_for("id_valid", 1, 5, n);
    chk("id_valid_lat", n, 0);
    id_ready = 1'b0;
    repeat (bp_id) begin
      done = 1'($urandom_range(0, 1));
      tick();
      chk("id_valid_held", id_valid, 1);
      chk("no_write_in_dispatch", valid, 0);
    end
    id_ready = 1'b1;
    done     = done_w_acc;
    tick();
    id_ready = 1'b0;
    done     = 1'b0;
    if (!done_w_acc) begin
      repeat (done_dly) begin
        tick();
        chk("no_early_write", valid, 0);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
    end

    wait_for("write_valid", 0, 5, n);
    chk("done_to_write", n, 0);
    ready = 1'b0;
    repeat (st_wr) tick();
    ready = 1'b1;
    tick();
    ready = 1'b0;

    if (hold_irq) begin
      wait_for("rearm_reclaim", 0, 20, n);
      chk("rearm_to_claim", n, REARM + 1);
    end else begin
      wait_for("rearm_idle", 2, 20, n);
      chk("rearm_len", n, REARM);
    end
  endtask

  initial begin
    #1000000;
    checks++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_run();
  end

  initial begin
    logic [31:0] rd;
    rst = 1'b1; irq = 1'b0; ready = 1'b0; id_ready = 1'b0; done = 1'b0; rdata = '0;
    tick();
    tick();
    chk("rst_valid",    valid,        0);
    chk("rst_wstrb",    wstrb,        0);
    chk("rst_wdata",    wdata,        0);
    chk("rst_address",  address,      CADDR);
    chk("rst_id_valid", id_valid,     0);
    chk("rst_id",       id,           0);
    chk("rst_busy",     busy,         0);
    chk("rst_spur",     spurious_cnt, 0);
    rst = 1'b0;
    tick();

    // Basic claim/dispatch/complete, done three cycles after the ID handshake.
    push_txn(32'h0000_0005);
    run_txn(32'h0000_0005, 0, 0, 0, 1'b0, 2, 1'b0, 1'b1);

    // Wait states on both bus transfers; upper rdata bits are ignored.
    push_txn(32'hABCD_0033);
    run_txn(32'hABCD_0033, 4, 4, 0, 1'b0, 1, 1'b0, 1'b1);

    // Spurious claims; the 2-bit counter saturates at 3.
    for (int i = 0; i < 5; i++) begin
      rd = $urandom & 32'hFFFF_FF80;
      push_txn(rd);
      run_txn(rd, $urandom_range(0, 2), 0, 0, 1'b0, 0, 1'b0, 1'b1);
    end

    // Consumer backpressure with done pulses that must be ignored.
    push_txn(32'h0000_0005);
    run_txn(32'h0000_0005, 0, 0, 10, 1'b0, 1, 1'b0, 1'b1);

    // irq held high: the next claim follows the settling interval.
    push_txn(32'h0000_0009);
    push_txn(32'h0000_007F);
    run_txn(32'h0000_0009, 0, 0, 0, 1'b1, 0, 1'b1, 1'b1);
    run_txn(32'h0000_007F, 1, 2, 2, 1'b0, 0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a claim.
    push_txn(32'h0000_0011);
    irq = 1'b1;
    begin
      int n;
      wait_for("claim_before_rst", 0, 20, n);
    end
    irq = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid",    valid,        0);
    chk("midrst_busy",     busy,         0);
    chk("midrst_spur",     spurious_cnt, 0);
    chk("midrst_id_valid", id_valid,     0);
    exp_q.delete();
    spur_exp       = 0;
    spur_small_exp = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Randomized transactions against the model.
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 3) == 0) rd = $urandom & 32'hFFFF_FF80;
      else rd = $urandom;
      push_txn(rd);
      run_txn(rd, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
              1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0, 1'b1);
      done = 1'($urandom_range(0, 1));
      tick();
      done = 1'b0;
      tick();
    end

    chk("queue_drained", exp_q.size(), 0);
    finish_run();
  end

endmodule
